// File: rtl/dpd_adapt_ctrl_pkg.sv
// Shared types and constants for the DPD adaptation sequencer.
// State encoding, narrow width aliases and the burst counter sizing helper.
package dpd_adapt_ctrl_pkg;

    typedef logic [3:0]  u4;
    typedef logic [23:0] u24;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ARM,
        ADAPT,
        GAP,
        DONE
    } dpd_ctrl_st_t;

    // Shortest low window the dpd core can still edge-detect between bursts.
    localparam int DPD_MIN_GAP = 3;

    function automatic int cnt_width(input int adapt_len, input int gap_len);
        int m;
        m = (adapt_len > gap_len) ? adapt_len : gap_len;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/dpd_adapt_ctrl_period_timer.sv
// Auto-repeat period down-counter: one expire pulse every period_i cycles while enabled.
// Disabled (auto_en=0 or period_i=0) keeps the counter reloaded with period_i.
module dpd_period_timer
    import dpd_adapt_ctrl_pkg::*;
#(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic                auto_en,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                expire
);

    logic [PERIOD_W-1:0] cnt;
    logic                run;

    assign run    = auto_en && (period_i != '0);
    assign expire = run && (cnt == PERIOD_W'(1));

    // Reset leaves the counter at 0; the first running cycle loads period_i.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cnt <= '0;
        end else if (!run || (cnt <= PERIOD_W'(1))) begin
            cnt <= period_i;
        end else begin
            cnt <= cnt - PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/dpd_adapt_ctrl.sv
// DPD LMS adaptation sequencer: merges sw/periodic requests, waits for a TX gap,
// then drives N bursts of dpd_adapt. Optional WAIT watchdog under DPD_ADAPT_WDOG_EN.
module dpd_adapt_ctrl
    import dpd_adapt_ctrl_pkg::*;
#(
    parameter int ADAPT_LEN = 1024,
    parameter int GAP_LEN   = 16,
    parameter int PERIOD_W  = 24
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic                sw_req,
    input  logic                auto_en,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [3:0]          n_iter_i,
    input  logic                tx_gap,
    input  logic                abort,
    output logic                dpd_adapt,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [3:0]          iter_cnt,
    output logic [15:0]         campaign_cnt,
    output dpd_ctrl_st_t        dbg_state
`ifdef DPD_ADAPT_WDOG_EN
    ,
    output logic                wdog_err
`endif
);

    localparam int GAP_EFF = (GAP_LEN < DPD_MIN_GAP) ? DPD_MIN_GAP : GAP_LEN;
    localparam int CNT_W   = cnt_width(ADAPT_LEN, GAP_EFF);

    dpd_ctrl_st_t     state;
    dpd_ctrl_st_t     next_state;
    logic [CNT_W-1:0] burst_cnt;
    logic             pending;
    logic             abort_q;
    logic             abort_hit;
    logic             tx_gap_q;
    u4                n_iter_q;
    logic             expire;
    logic             adapt_end;
    logic             gap_end;
    logic             last_iter;
    logic             wdog_fire;

    dpd_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk      (clk),
        .reset_b  (reset_b),
        .auto_en  (auto_en),
        .period_i (period_i),
        .expire   (expire)
    );

    assign abort_hit = abort_q || abort;
    assign adapt_end = (state == ADAPT) && (burst_cnt == CNT_W'(ADAPT_LEN - 1));
    assign gap_end   = (state == GAP) && (burst_cnt == CNT_W'(GAP_EFF - 1));
    assign last_iter = ((iter_cnt + 4'd1) == n_iter_q);

`ifdef DPD_ADAPT_WDOG_EN
    localparam int WDOG_LEN = 2**20;

    logic [19:0] wdog_cnt;

    assign wdog_fire = (state == WAIT) && !tx_gap_q && (wdog_cnt == 20'(WDOG_LEN - 1));

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            if ((state == WAIT) && !tx_gap_q) begin
                wdog_cnt <= wdog_cnt + 20'd1;
            end else begin
                wdog_cnt <= '0;
            end
            if (wdog_fire) begin
                wdog_err <= 1'b1;
            end else if (sw_req) begin
                wdog_err <= 1'b0;
            end
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (pending) next_state = WAIT;
            WAIT: begin
                if (abort_hit || wdog_fire) begin
                    next_state = DONE;
                end else if (tx_gap_q) begin
                    next_state = ARM;
                end
            end
            ARM:     next_state = abort_hit ? DONE : ADAPT;
            ADAPT:   if (adapt_end) next_state = GAP;
            GAP:     if (gap_end) next_state = (last_iter || abort_hit) ? DONE : ADAPT;
            // A request held through the campaign skips IDLE to keep the low window short.
            DONE:    next_state = (pending && !abort_q) ? WAIT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state     <= IDLE;
            dpd_adapt <= 1'b0;
            tx_gap_q  <= 1'b0;
        end else begin
            state     <= next_state;
            dpd_adapt <= (next_state == ADAPT);
            tx_gap_q  <= tx_gap;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            burst_cnt <= '0;
        end else if (next_state != state) begin
            burst_cnt <= '0;
        end else if ((state == ADAPT) || (state == GAP)) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
        end
    end

    // A new request in the consuming cycle wins, so back-to-back requests are not lost.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pending <= 1'b0;
        end else if ((state == DONE) && abort_q) begin
            pending <= 1'b0;
        end else if (sw_req || expire) begin
            pending <= 1'b1;
        end else if ((next_state == WAIT) && (state != WAIT)) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            abort_q <= 1'b0;
        end else if (state == DONE) begin
            abort_q <= 1'b0;
        end else if ((abort && (state != IDLE)) || wdog_fire) begin
            abort_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            n_iter_q     <= 4'd1;
            iter_cnt     <= 4'd0;
            campaign_cnt <= 16'd0;
        end else begin
            if (state == ARM) begin
                n_iter_q <= (n_iter_i == 4'd0) ? 4'd1 : n_iter_i;
                iter_cnt <= 4'd0;
            end else if (gap_end) begin
                iter_cnt <= iter_cnt + 4'd1;
            end
            if ((state == DONE) && !abort_q && (campaign_cnt != 16'hFFFF)) begin
                campaign_cnt <= campaign_cnt + 16'd1;
            end
        end
    end

    assign busy      = state inside {ARM, ADAPT, GAP, DONE};
    assign done      = (state == DONE) && !abort_q;
    assign aborted   = (state == DONE) && abort_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_dpd_adapt_ctrl.sv
// Directed + randomized bench for dpd_adapt_ctrl: burst timing is predicted from
// request/tx_gap cycles with plain arithmetic and compared against a dpd_adapt edge monitor.
`timescale 1ns/1ps
module tb_dpd_adapt_ctrl;
    import dpd_adapt_ctrl_pkg::*;

    localparam int A  = 1024;
    localparam int G  = 16;
    localparam int P  = A + G;
    localparam int PW = 24;

    logic          clk      = 1'b0;
    logic          reset_b  = 1'b0;
    logic          sw_req   = 1'b0;
    logic          auto_en  = 1'b0;
    logic [PW-1:0] period_i = '0;
    logic [3:0]    n_iter_i = 4'd0;
    logic          tx_gap   = 1'b0;
    logic          abort    = 1'b0;
    logic          dpd_adapt;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [3:0]    iter_cnt;
    logic [15:0]   campaign_cnt;
    dpd_ctrl_st_t  dbg_state;
`ifdef DPD_ADAPT_WDOG_EN
    logic          wdog_err;
`endif

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int model_cnt = 0;
    int rise_q[$];
    int fall_q[$];
    int done_q[$];
    int abrt_q[$];
    logic [31:0] exp_q[$];
    logic prev_adapt = 1'b0;

    dpd_adapt_ctrl #(
        .ADAPT_LEN (A),
        .GAP_LEN   (G),
        .PERIOD_W  (PW)
    ) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .sw_req       (sw_req),
        .auto_en      (auto_en),
        .period_i     (period_i),
        .n_iter_i     (n_iter_i),
        .tx_gap       (tx_gap),
        .abort        (abort),
        .dpd_adapt    (dpd_adapt),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .iter_cnt     (iter_cnt),
        .campaign_cnt (campaign_cnt),
        .dbg_state    (dbg_state)
`ifdef DPD_ADAPT_WDOG_EN
        ,
        .wdog_err     (wdog_err)
`endif
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // edge monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (dpd_adapt && !prev_adapt) rise_q.push_back(cyc);
        if (!dpd_adapt && prev_adapt) fall_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
        if (aborted) abrt_q.push_back(cyc);
        prev_adapt = dpd_adapt;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic clear_mon();
        rise_q.delete();
        fall_q.delete();
        done_q.delete();
        abrt_q.delete();
    endtask

    // drives sw_req for one cycle; c is the cycle it is sampled in
    task automatic pulse_sw(output int c);
        @(negedge clk);
        sw_req = 1'b1;
        c = cyc;
        @(negedge clk);
        sw_req = 1'b0;
    endtask

    // expected: n bursts, rise k at s+k*P, fall A later, end pulse at s+n*P
    task automatic check_campaign(input string tag, input int s, input int n, input bit ab);
        int e;
        int r;
        int obs;
        e = s + n * P;
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(32'(s + k * P));
        if (cyc < s + 1) begin
            wait_until(s + 1);
            chk({tag, "_busy_run"}, int'(busy), 1);
            chk({tag, "_iter_clr"}, int'(iter_cnt), 0);
        end
        wait_until(e + 1);
        chk({tag, "_n_rise"}, rise_q.size(), n);
        chk({tag, "_n_fall"}, fall_q.size(), n);
        while (exp_q.size() > 0) begin
            r = int'(exp_q.pop_front());
            obs = (rise_q.size() > 0) ? rise_q.pop_front() : -1;
            chk({tag, "_rise_cyc"}, obs, r);
            obs = (fall_q.size() > 0) ? fall_q.pop_front() : -1;
            chk({tag, "_fall_cyc"}, obs, r + A);
        end
        if (!ab) model_cnt++;
        chk({tag, "_n_done"}, done_q.size(), ab ? 0 : 1);
        chk({tag, "_n_aborted"}, abrt_q.size(), ab ? 1 : 0);
        if (ab) begin
            obs = (abrt_q.size() > 0) ? abrt_q[0] : -1;
            chk({tag, "_aborted_cyc"}, obs, e);
        end else begin
            obs = (done_q.size() > 0) ? done_q[0] : -1;
            chk({tag, "_done_cyc"}, obs, e);
        end
        done_q.delete();
        abrt_q.delete();
        chk({tag, "_iter_cnt"}, int'(iter_cnt), n);
        chk({tag, "_campaign_cnt"}, int'(campaign_cnt), model_cnt);
        chk({tag, "_busy_end"}, int'(busy), 0);
    endtask

    initial begin
        int c;
        int c2;
        int s;
        int t;
        int n;
        int d;
        int r0;
        int obs;

        // reset state
        tick(3);
        chk("rst_adapt", int'(dpd_adapt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_aborted", int'(aborted), 0);
        chk("rst_iter", int'(iter_cnt), 0);
        chk("rst_campaigns", int'(campaign_cnt), 0);
        chk("rst_state", int'(dbg_state), int'(IDLE));
        reset_b = 1'b1;
        tick(5);
        chk("idle_no_burst", rise_q.size(), 0);

        // two bursts, tx slot already free: latency 4 from sw_req
        tx_gap   = 1'b1;
        n_iter_i = 4'd2;
        tick(2);
        clear_mon();
        pulse_sw(c);
        check_campaign("two_iter", c + 4, 2, 1'b0);

        // n_iter = 0 behaves as a single burst
        n_iter_i = 4'd0;
        clear_mon();
        pulse_sw(c);
        check_campaign("n_zero", c + 4, 1, 1'b0);

        // request while busy is held and served after done, low window G+3
        n_iter_i = 4'd1;
        clear_mon();
        pulse_sw(c);
        s = c + 4;
        wait_until(s + 200);
        pulse_sw(c2);
        check_campaign("held_first", s, 1, 1'b0);
        check_campaign("held_second", s + P + 3, 1, 1'b0);

        // tx slot busy for 300 cycles
        tx_gap = 1'b0;
        tick(2);
        clear_mon();
        pulse_sw(c);
        tick(300);
        chk("stall_no_rise", rise_q.size(), 0);
        chk("stall_adapt_low", int'(dpd_adapt), 0);
        chk("stall_not_busy", int'(busy), 0);
        tx_gap = 1'b1;
        t = cyc;
        check_campaign("stall", t + 3, 1, 1'b0);

        // abort 100 cycles into the first of four bursts
        n_iter_i = 4'd4;
        clear_mon();
        pulse_sw(c);
        s = c + 4;
        wait_until(s + 100);
        chk("abort_in_burst", int'(dpd_adapt), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_campaign("abort", s, 1, 1'b1);

        // periodic requests, one coinciding with an sw_req
        n_iter_i = 4'd1;
        period_i = 24'd5000;
        clear_mon();
        auto_en  = 1'b1;
        for (int i = 0; i < 6000 && rise_q.size() == 0; i++) @(negedge clk);
        chk("auto_first_seen", int'(rise_q.size() > 0), 1);
        r0 = (rise_q.size() > 0) ? rise_q[0] : cyc;
        wait_until(r0 - 4 + 5000);
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        wait_until(r0 + 10000 + P + 10);
        auto_en = 1'b0;
        chk("auto_n_rise", rise_q.size(), 3);
        for (int k = 1; k < 3; k++) begin
            obs = (rise_q.size() > k) ? (rise_q[k] - rise_q[k - 1]) : -1;
            chk("auto_interval", obs, 5000);
        end
        chk("auto_n_done", done_q.size(), 3);
        model_cnt += 3;
        chk("auto_campaigns", int'(campaign_cnt), model_cnt);
        tick(10);

        // randomized campaigns: random length and random tx slot delay
        for (int round = 0; round < 3; round++) begin
            n = $urandom_range(0, 4);
            d = $urandom_range(0, 30);
            n_iter_i = 4'(n);
            tx_gap = (d == 0);
            tick(2);
            clear_mon();
            pulse_sw(c);
            if (d > 0) begin
                wait_until(c + d);
                tx_gap = 1'b1;
                s = c + d + 3;
            end else begin
                s = c + 4;
            end
            check_campaign($sformatf("rand%0d_n%0d_d%0d", round, n, d), s, (n == 0) ? 1 : n, 1'b0);
        end

        // asynchronous reset in the middle of a burst
        tx_gap   = 1'b1;
        n_iter_i = 4'd1;
        clear_mon();
        pulse_sw(c);
        wait_until(c + 4 + 50);
        chk("pre_reset_adapt", int'(dpd_adapt), 1);
        #2;
        reset_b = 1'b0;
        #1;
        chk("async_adapt_low", int'(dpd_adapt), 0);
        chk("async_busy_low", int'(busy), 0);
        tick(2);
        reset_b = 1'b1;
        model_cnt = 0;
        clear_mon();
        tick(20);
        chk("post_reset_state", int'(dbg_state), int'(IDLE));
        chk("post_reset_no_burst", rise_q.size(), 0);
        chk("post_reset_campaigns", int'(campaign_cnt), model_cnt);
        chk("post_reset_iter", int'(iter_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
